ccff_chain_loader: RTL

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

---
 rtl/ccff_cfg_pkg.sv | 36 +++
 rtl/ccff_piso.sv | 63 ++++++
 rtl/ccff_chain_loader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ccff_cfg_pkg.sv
// ---------------------------------------------------------------------------
// ccff_cfg_pkg
// Shared configuration for the configuration-chain loader: loader state
// encoding, counter/byte widths and the default chain geometry.
// No ports (package).
// ---------------------------------------------------------------------------
package ccff_cfg_pkg;

  localparam int CHAIN_LEN_W   = 16;
  localparam int BYTE_W        = 8;
  localparam int BIT_CNT_W     = 3;
  localparam int CLR_CNT_W     = 8;
  localparam int CHAIN_LEN_DEF = 2048;
  localparam int CLR_CYC_DEF   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FETCH = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } ccff_state_e;

  // A load is in flight from the start of the clear until the last bit leaves.
  function automatic logic state_is_busy(input ccff_state_e st);
    logic res;
    case (st)
      ST_CLEAR: res = 1'b1;
      ST_FETCH: res = 1'b1;
      ST_SHIFT: res = 1'b1;
      default:  res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ccff_piso.sv
// ---------------------------------------------------------------------------
// ccff_piso
// 8-bit parallel-load, shift-right register with a 3-bit bit counter.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   clr          : synchronous clear of register and counter
//   load, din    : parallel load of a new byte (counter restarts at 0)
//   shift        : advance one bit towards bit 0, counter increments
//   next_bit     : bit that sits at position 0 after the next shift
//   last_bit     : current bit is the eighth of the byte
// ---------------------------------------------------------------------------
module ccff_piso
  import ccff_cfg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic              shift,
  input  logic [BYTE_W-1:0] din,
  output logic              next_bit,
  output logic              last_bit
);

  logic [BYTE_W-1:0]    sreg_q, sreg_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  // Next-value logic: clear beats load beats shift.
  always_comb begin
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    if (clr) begin
      sreg_d    = {BYTE_W{1'b0}};
      bit_cnt_d = {BIT_CNT_W{1'b0}};
    end else if (load) begin
      sreg_d    = din;
      bit_cnt_d = {BIT_CNT_W{1'b0}};
    end else if (shift) begin
      // Rotating keeps every bit live; wrapped bits are never emitted because
      // the owner reloads or leaves after the eighth shift.
      sreg_d    = {sreg_q[0], sreg_q[BYTE_W-1:1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end else begin
      sreg_d    = sreg_q;
      bit_cnt_d = bit_cnt_q;
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg_q    <= {BYTE_W{1'b0}};
      bit_cnt_q <= {BIT_CNT_W{1'b0}};
    end else begin
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign next_bit = sreg_q[1];
  assign last_bit = (bit_cnt_q == 3'd7);

endmodule

// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader
// Clears a fabric configuration chain, then streams a byte-wide bitstream
// into it LSB first, exactly CHAIN_LEN bits, watching the chain tail for
// stray ones (the chain was just cleared, so any 1 is a fault).
// Ports:
//   prog_clk, prog_reset_n : clock, synchronous active-low reset
//   start, abort           : begin a load (IDLE only) / cancel from any state
//   bs_data, bs_valid      : bitstream byte source
//   bs_ready               : byte accepted this cycle when bs_valid is high
//   ccff_head, shift_en    : serial data and advance strobe into the chain
//   ccff_tail              : chain output, checked during shifting
//   chain_reset            : active-high fabric chain clear
//   busy, done, error      : status (done is a one-cycle pulse, error sticky)
// ---------------------------------------------------------------------------
module ccff_chain_loader
  import ccff_cfg_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int unsigned CLR_CYC   = CLR_CYC_DEF
)(
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [BYTE_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              shift_en,
  output logic              chain_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [CHAIN_LEN_W-1:0] CHAIN_LEN_V = CHAIN_LEN_W'(CHAIN_LEN);
  localparam logic [CLR_CNT_W-1:0]   CLR_CYC_V   = CLR_CNT_W'(CLR_CYC);

  ccff_state_e            state_q, state_d;
  logic [CLR_CNT_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [CHAIN_LEN_W-1:0] pos_cnt_q, pos_cnt_d;
  logic [CHAIN_LEN_W-1:0] pos_inc_s;
  logic                   error_q, error_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   chain_reset_q, chain_reset_d;
  logic                   shift_en_q, shift_en_d;
  logic                   ccff_head_q, ccff_head_d;

  logic piso_clr_s, piso_load_s, piso_shift_s;
  logic piso_next_bit_s, piso_last_bit_s;

  ccff_piso u_piso (
    .clk      (prog_clk),
    .rst_n    (prog_reset_n),
    .clr      (piso_clr_s),
    .load     (piso_load_s),
    .shift    (piso_shift_s),
    .din      (bs_data),
    .next_bit (piso_next_bit_s),
    .last_bit (piso_last_bit_s)
  );

  assign pos_inc_s = pos_cnt_q + 16'd1;

  // Next-state, counters and sticky error; abort overrides every transition.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    pos_cnt_d    = pos_cnt_q;
    error_d      = error_q;
    piso_clr_s   = 1'b0;
    piso_load_s  = 1'b0;
    piso_shift_s = 1'b0;
    if (abort) begin
      state_d    = ST_IDLE;
      piso_clr_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d    = ST_CLEAR;
            clr_cnt_d  = CLR_CYC_V;
            pos_cnt_d  = {CHAIN_LEN_W{1'b0}};
            error_d    = 1'b0;
            piso_clr_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_q == 8'd1) begin
            state_d   = ST_FETCH;
            clr_cnt_d = {CLR_CNT_W{1'b0}};
          end else begin
            clr_cnt_d = clr_cnt_q - 8'd1;
          end
        end
        ST_FETCH: begin
          if (bs_valid) begin
            state_d     = ST_SHIFT;
            piso_load_s = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_SHIFT: begin
          piso_shift_s = 1'b1;
          pos_cnt_d    = pos_inc_s;
          // Every SHIFT cycle is before the chain is full, so a 1 is a fault.
          if (ccff_tail) begin
            error_d = 1'b1;
          end else begin
            error_d = error_q;
          end
          // Chain length wins over byte boundary: leftover bits are dropped.
          if (pos_inc_s == CHAIN_LEN_V) begin
            state_d = ST_DONE;
          end else if (piso_last_bit_s) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_SHIFT;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output values for the coming cycle, derived from the state being entered.
  always_comb begin
    busy_d        = state_is_busy(state_d);
    done_d        = (state_d == ST_DONE);
    chain_reset_d = (state_d == ST_CLEAR);
    shift_en_d    = (state_d == ST_SHIFT);
    if (state_d == ST_SHIFT) begin
      // Entering SHIFT presents bit 0 of the new byte; staying presents the
      // bit that the register is about to move into position 0.
      ccff_head_d = piso_load_s ? bs_data[0] : piso_next_bit_s;
    end else begin
      ccff_head_d = 1'b0;
    end
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state_q       <= ST_IDLE;
      clr_cnt_q     <= {CLR_CNT_W{1'b0}};
      pos_cnt_q     <= {CHAIN_LEN_W{1'b0}};
      error_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      chain_reset_q <= 1'b0;
      shift_en_q    <= 1'b0;
      ccff_head_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      pos_cnt_q     <= pos_cnt_d;
      error_q       <= error_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      chain_reset_q <= chain_reset_d;
      shift_en_q    <= shift_en_d;
      ccff_head_q   <= ccff_head_d;
    end
  end

  // Ready is decoded from the state and forced low while reset is applied so
  // that no handshake can complete into a load being abandoned.
  assign bs_ready    = (state_q == ST_FETCH) && prog_reset_n;
  assign ccff_head   = ccff_head_q;
  assign shift_en    = shift_en_q;
  assign chain_reset = chain_reset_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule
